// File: rtl/midi_note_parser_pkg.sv
// ---------------------------------------------------------------------------
// midi_note_parser_pkg
//
// Shared types and constants for the MIDI front end:
//   note_en_t        - note event kind handed to the polyphony controller
//   MIDI_* constants - status nibbles and system status bytes
//   midi_state_t     - parser FSM states
//   status_decode_t  - result of classifying one status byte
// ---------------------------------------------------------------------------
package midi_note_parser_pkg;

  typedef enum logic {
    NOTE_OFF = 1'b0,
    NOTE_ON  = 1'b1
  } note_en_t;

  // Channel-voice status nibbles (upper four bits of the status byte)
  localparam logic [3:0] MIDI_NOTE_OFF  = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON   = 4'h9;
  localparam logic [3:0] MIDI_POLY_AT   = 4'hA;
  localparam logic [3:0] MIDI_CC        = 4'hB;
  localparam logic [3:0] MIDI_PROGRAM   = 4'hC;
  localparam logic [3:0] MIDI_CHAN_AT   = 4'hD;
  localparam logic [3:0] MIDI_PITCH     = 4'hE;
  localparam logic [3:0] MIDI_SYSTEM    = 4'hF;

  // System status bytes
  localparam logic [7:0] MIDI_SYSEX_START = 8'hF0;
  localparam logic [7:0] MIDI_MTC_QF      = 8'hF1;
  localparam logic [7:0] MIDI_SONG_POS    = 8'hF2;
  localparam logic [7:0] MIDI_SONG_SEL    = 8'hF3;
  localparam logic [7:0] MIDI_SYSEX_END   = 8'hF7;
  localparam logic [7:0] MIDI_RT_MIN      = 8'hF8;

  typedef enum logic [2:0] {
    WAIT_STATUS = 3'd0,
    NOTE_KEY    = 3'd1,
    NOTE_VEL    = 3'd2,
    SKIP2       = 3'd3,
    SKIP1       = 3'd4,
    SYSEX       = 3'd5
  } midi_state_t;

  typedef struct packed {
    midi_state_t next_state;  // state entered after this status byte
    logic        rs_valid;    // status may be reused as running status
    logic        is_note;     // Note On / Note Off (subject to channel filter)
  } status_decode_t;

endpackage

// File: rtl/midi_note_parser.sv
// ---------------------------------------------------------------------------
// midi_note_parser
//
// Turns the raw UART MIDI byte stream into single-cycle note events.
// Note On / Note Off are decoded (with running status and channel filter);
// every other message is consumed without losing byte alignment.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   byte_valid   byte_in valid strobe from UART RX
//   byte_in      received MIDI byte
//   channel      channel to accept, sampled at each status byte
//   input_en     one-cycle pulse: note event valid
//   note_in_en   NOTE_ON / NOTE_OFF for the event (held)
//   note_in      key number (held)
//   velocity_in  velocity (held)
//   parse_error  one-cycle pulse on a protocol violation
// ---------------------------------------------------------------------------
module midi_note_parser
  import midi_note_parser_pkg::*;
#(
  parameter int OMNI      = 0,
  parameter int SYSEX_MAX = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  input  logic [3:0] channel,
  output logic       input_en,
  output note_en_t   note_in_en,
  output logic [6:0] note_in,
  output logic [6:0] velocity_in,
  output logic       parse_error
);

  localparam int CNT_W = (SYSEX_MAX > 0) ? $clog2(SYSEX_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYSEX_MAX);

  // Classify a status byte (bit 7 set, not real-time).
  function automatic status_decode_t decode_status(input logic [7:0] b);
    status_decode_t d;
    d.next_state = WAIT_STATUS;
    d.rs_valid   = 1'b0;
    d.is_note    = 1'b0;
    case (b[7:4])
      MIDI_NOTE_OFF, MIDI_NOTE_ON: begin
        d.next_state = NOTE_KEY;
        d.rs_valid   = 1'b1;
        d.is_note    = 1'b1;
      end
      MIDI_POLY_AT, MIDI_CC, MIDI_PITCH: begin
        d.next_state = SKIP2;
        d.rs_valid   = 1'b1;
      end
      MIDI_PROGRAM, MIDI_CHAN_AT: begin
        d.next_state = SKIP1;
        d.rs_valid   = 1'b1;
      end
      MIDI_SYSTEM: begin
        // System messages never establish running status.
        case (b)
          MIDI_SYSEX_START:          d.next_state = SYSEX;
          MIDI_MTC_QF, MIDI_SONG_SEL: d.next_state = SKIP1;
          MIDI_SONG_POS:             d.next_state = SKIP2;
          default:                   d.next_state = WAIT_STATUS;
        endcase
      end
      default: d.next_state = WAIT_STATUS;
    endcase
    return d;
  endfunction

  midi_state_t      state_q, state_d;
  logic             rs_valid_q, rs_valid_d;
  logic             type_on_q, type_on_d;    // latched status was 0x9n
  logic [6:0]       key_q, key_d;
  logic             half_q, half_d;          // first SKIP2 data byte seen
  // A message is "open" once its status or a data byte has arrived and it
  // is not yet complete. A status byte landing while open is a violation;
  // one landing between complete running-status messages is legal.
  logic             open_q, open_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             input_en_q, input_en_d;
  note_en_t         note_en_q, note_en_d;
  logic [6:0]       note_q, note_d;
  logic [6:0]       vel_q, vel_d;
  logic             perr_q, perr_d;

  logic             is_status;
  logic             is_rt;
  logic             ch_ok;
  status_decode_t   dec;

  always_comb begin
    state_d    = state_q;
    rs_valid_d = rs_valid_q;
    type_on_d  = type_on_q;
    key_d      = key_q;
    half_d     = half_q;
    open_d     = open_q;
    cnt_d      = cnt_q;
    input_en_d = 1'b0;
    note_en_d  = note_en_q;
    note_d     = note_q;
    vel_d      = vel_q;
    perr_d     = 1'b0;

    is_status  = byte_in[7];
    is_rt      = (byte_in >= MIDI_RT_MIN);
    dec        = decode_status(byte_in);
    ch_ok      = (OMNI != 0) || (byte_in[3:0] == channel);

    if (byte_valid && !is_rt) begin
      if (is_status) begin
        if (open_q && (state_q != SYSEX) && (state_q != WAIT_STATUS)) begin
          perr_d = 1'b1;
        end
        state_d    = dec.next_state;
        rs_valid_d = dec.rs_valid;
        type_on_d  = byte_in[4];  // distinguishes 0x9n from 0x8n
        half_d     = 1'b0;
        cnt_d      = '0;
        open_d     = (dec.next_state == NOTE_KEY) ||
                     (dec.next_state == SKIP1)    ||
                     (dec.next_state == SKIP2);
        // Foreign-channel notes are consumed like any two-byte message.
        if (dec.is_note && !ch_ok) begin
          state_d = SKIP2;
        end
      end else begin
        case (state_q)
          WAIT_STATUS: perr_d = 1'b1;
          NOTE_KEY: begin
            key_d   = byte_in[6:0];
            open_d  = 1'b1;
            state_d = NOTE_VEL;
          end
          NOTE_VEL: begin
            input_en_d = 1'b1;
            note_d     = key_q;
            vel_d      = byte_in[6:0];
            note_en_d  = (type_on_q && (byte_in[6:0] != 7'd0)) ? NOTE_ON : NOTE_OFF;
            open_d     = 1'b0;
            state_d    = NOTE_KEY;
          end
          SKIP2: begin
            if (!half_q) begin
              half_d = 1'b1;
              open_d = 1'b1;
            end else begin
              half_d  = 1'b0;
              open_d  = 1'b0;
              state_d = rs_valid_q ? SKIP2 : WAIT_STATUS;
            end
          end
          SKIP1: begin
            open_d  = 1'b0;
            state_d = rs_valid_q ? SKIP1 : WAIT_STATUS;
          end
          SYSEX: begin
            if (cnt_q == CNT_MAX) begin
              perr_d  = 1'b1;
              cnt_d   = '0;
              state_d = WAIT_STATUS;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: state_d = WAIT_STATUS;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= WAIT_STATUS;
      rs_valid_q <= 1'b0;
      type_on_q  <= 1'b0;
      key_q      <= 7'd0;
      half_q     <= 1'b0;
      open_q     <= 1'b0;
      cnt_q      <= '0;
      input_en_q <= 1'b0;
      note_en_q  <= NOTE_OFF;
      note_q     <= 7'd0;
      vel_q      <= 7'd0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_valid_q <= rs_valid_d;
      type_on_q  <= type_on_d;
      key_q      <= key_d;
      half_q     <= half_d;
      open_q     <= open_d;
      cnt_q      <= cnt_d;
      input_en_q <= input_en_d;
      note_en_q  <= note_en_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      perr_q     <= perr_d;
    end
  end

  assign input_en    = input_en_q;
  assign note_in_en  = note_en_q;
  assign note_in     = note_q;
  assign velocity_in = vel_q;
  assign parse_error = perr_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// ---------------------------------------------------------------------------
// tb_midi_note_parser
//
// Directed vector table, hand-written corner sequences (reset mid-message,
// SysEx length limit) and a randomized byte stream checked against a
// message-level reference model.
// ---------------------------------------------------------------------------
module tb_midi_note_parser;
  import midi_note_parser_pkg::*;

  localparam int SYSEX_MAX = 1023;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic [3:0] channel = 4'd0;
  logic       input_en;
  note_en_t   note_in_en;
  logic [6:0] note_in;
  logic [6:0] velocity_in;
  logic       parse_error;

  midi_note_parser #(.OMNI(0), .SYSEX_MAX(SYSEX_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .channel    (channel),
    .input_en   (input_en),
    .note_in_en (note_in_en),
    .note_in    (note_in),
    .velocity_in(velocity_in),
    .parse_error(parse_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit en, input bit perr,
                           input bit on, input int n, input int v);
    chk({tag, ".input_en"},    32'(input_en),    32'(en));
    chk({tag, ".parse_error"}, 32'(parse_error), 32'(perr));
    chk({tag, ".note_in_en"},  32'(note_in_en),  32'(on));
    chk({tag, ".note_in"},     32'(note_in),     32'(n));
    chk({tag, ".velocity_in"}, 32'(velocity_in), 32'(v));
  endtask

  // Present one byte (or idle) for one clock; outputs sampled 1 ns after edge.
  task automatic tick(input bit v, input logic [7:0] b);
    byte_valid = v;
    byte_in    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(0, 8'h00);
    tick(0, 8'h00);
    reset = 1'b1;
  endtask

  // ------------------------------------------------------------------
  // Directed vector table
  // ------------------------------------------------------------------
  typedef struct {
    bit         v;
    logic [3:0] ch;
    logic [7:0] b;
    bit         ev;
    bit         on;
    int         n;
    int         vel;
    bit         perr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit v, input logic [3:0] ch, input logic [7:0] b,
                     input bit ev, input bit on, input int n, input int vel, input bit perr);
    vec_t r;
    r.v = v; r.ch = ch; r.b = b; r.ev = ev; r.on = on; r.n = n; r.vel = vel; r.perr = perr;
    vecs.push_back(r);
  endtask
  task automatic nb(input logic [3:0] ch, input logic [7:0] b); add(1, ch, b, 0, 0, 0, 0, 0); endtask
  task automatic pb(input logic [3:0] ch, input logic [7:0] b); add(1, ch, b, 0, 0, 0, 0, 1); endtask
  task automatic eb(input logic [3:0] ch, input logic [7:0] b, input bit on, input int n, input int v);
    add(1, ch, b, 1, on, n, v, 0);
  endtask
  task automatic idle(input logic [3:0] ch); add(0, ch, 8'hC0, 0, 0, 0, 0, 0); endtask

  // ------------------------------------------------------------------
  // Reference model: message-level view (status + collected data bytes)
  // ------------------------------------------------------------------
  int         m_cur;       // status byte of message being collected, -1 none
  bit         m_rs_keep;   // status survives as running status
  int         m_need;      // data bytes the current status requires
  logic [6:0] m_data[$];
  bit         m_fresh;     // status seen, no data yet
  bit         m_accept;    // channel matched at status time
  bit         m_sysex;
  int         m_sx;
  bit         m_on;
  int         m_n, m_v;

  task automatic model_reset();
    m_cur = -1; m_rs_keep = 0; m_need = 0; m_data.delete(); m_fresh = 0;
    m_accept = 0; m_sysex = 0; m_sx = 0; m_on = 0; m_n = 0; m_v = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic [3:0] ch,
                            output bit ev, output bit perr);
    int hi;
    ev = 0;
    perr = 0;
    hi = int'(b[7:4]);
    if (b >= 8'hF8) return;
    if (b[7]) begin
      perr = !m_sysex && (m_fresh || m_data.size() > 0);
      m_data.delete();
      m_sysex = (b == 8'hF0);
      m_sx = 0;
      m_fresh = 0;
      m_cur = -1;
      m_rs_keep = (hi < 15);
      case (hi)
        8, 9, 10, 11, 14: m_need = 2;
        12, 13:           m_need = 1;
        default: m_need = (b == 8'hF1 || b == 8'hF3) ? 1 : (b == 8'hF2) ? 2 : 0;
      endcase
      if (m_need > 0) begin
        m_cur = int'(b);
        m_fresh = 1;
        m_accept = (b[3:0] == ch);
      end
    end else if (m_sysex) begin
      if (m_sx == SYSEX_MAX) begin
        perr = 1;
        m_sysex = 0;
      end else begin
        m_sx++;
      end
    end else if (m_cur < 0) begin
      perr = 1;
    end else begin
      m_data.push_back(b[6:0]);
      m_fresh = 0;
      if (m_data.size() == m_need) begin
        if ((m_cur >> 4) == 8 || (m_cur >> 4) == 9) begin
          if (m_accept) begin
            ev = 1;
            m_n = int'(m_data[0]);
            m_v = int'(m_data[1]);
            m_on = ((m_cur >> 4) == 9) && (m_v != 0);
          end
        end
        m_data.delete();
        if (!m_rs_keep) m_cur = -1;
      end
    end
  endtask

  // ------------------------------------------------------------------
  initial begin
    bit         exp_on;
    int         exp_n, exp_v;
    int         sx_bad;
    bit         ev, perr;
    logic [7:0] b;
    bit         v;
    int         r;
    logic [3:0] nib;

    // Reset state
    do_reset();
    check_out("reset", 0, 0, 0, 0, 0);

    // ---------------- vector table ----------------
    nb(0, 8'h90); nb(0, 8'h3C); eb(0, 8'h64, 1, 60, 100);
    nb(0, 8'h40); eb(0, 8'h00, 0, 64, 0);
    nb(2, 8'h91); nb(2, 8'h3C); nb(2, 8'h64);
    nb(2, 8'h82); nb(2, 8'h3C); eb(2, 8'h10, 0, 60, 16);
    nb(0, 8'h90); nb(0, 8'h3C); nb(0, 8'hF8); eb(0, 8'h64, 1, 60, 100);
    nb(0, 8'hB0); nb(0, 8'h07); nb(0, 8'h7F); nb(0, 8'hF0); nb(0, 8'h01);
    nb(0, 8'h02); nb(0, 8'hF7); nb(0, 8'h90); nb(0, 8'h45); eb(0, 8'h20, 1, 69, 32);
    nb(0, 8'h90); nb(0, 8'h3C); pb(0, 8'h80); nb(0, 8'h3C); eb(0, 8'h00, 0, 60, 0);
    nb(0, 8'h90); nb(0, 8'h3E); eb(0, 8'h00, 0, 62, 0);
    nb(0, 8'hC0); nb(0, 8'h05); nb(0, 8'h06); nb(0, 8'h07); nb(0, 8'hC0);
    pb(0, 8'h90); nb(0, 8'h3C); eb(0, 8'h7F, 1, 60, 127);
    nb(0, 8'hF2); nb(0, 8'h01); nb(0, 8'h02); pb(0, 8'h03);
    nb(0, 8'hF1); nb(0, 8'h11); pb(0, 8'h12);
    nb(0, 8'h90); nb(0, 8'h41); pb(0, 8'hF6); pb(0, 8'h40);
    nb(0, 8'h90); idle(0); nb(0, 8'h30); idle(0); eb(0, 8'h50, 1, 48, 80);
    nb(0, 8'h7F); eb(0, 8'h7F, 1, 127, 127);
    nb(5, 8'h93); nb(3, 8'h3C); nb(3, 8'h40);
    nb(3, 8'h93); nb(3, 8'h3C); eb(3, 8'h40, 1, 60, 64);
    nb(0, 8'h3D); eb(0, 8'h41, 1, 61, 65);
    nb(0, 8'hFE); nb(0, 8'h3E); nb(0, 8'hFF); eb(0, 8'h00, 0, 62, 0);
    nb(0, 8'hE0); nb(0, 8'h00); nb(0, 8'h40); nb(0, 8'h01); nb(0, 8'h02);
    nb(0, 8'h80); nb(0, 8'h10); eb(0, 8'h20, 0, 16, 32);
    nb(0, 8'hF7); pb(0, 8'h22);
    nb(0, 8'hD0); pb(0, 8'hA0); nb(0, 8'h01); nb(0, 8'h02); nb(0, 8'h03);
    pb(0, 8'h90); nb(0, 8'h10); eb(0, 8'h11, 1, 16, 17);

    exp_on = 0; exp_n = 0; exp_v = 0;
    foreach (vecs[i]) begin
      channel = vecs[i].ch;
      tick(vecs[i].v, vecs[i].b);
      if (vecs[i].ev) begin
        exp_on = vecs[i].on; exp_n = vecs[i].n; exp_v = vecs[i].vel;
      end
      check_out($sformatf("vec%0d_b%02h", i, vecs[i].b), vecs[i].ev, vecs[i].perr,
                exp_on, exp_n, exp_v);
    end

    // ---------------- reset mid-message ----------------
    channel = 4'd0;
    tick(1, 8'h90); tick(1, 8'h3C);
    check_out("rstmid_pre", 0, 0, 1, 16, 17);
    reset = 1'b0;
    tick(0, 8'h00);
    check_out("rstmid_in_reset", 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick(1, 8'h64);
    check_out("rstmid_stray", 0, 1, 0, 0, 0);

    // ---------------- SysEx length limit ----------------
    tick(1, 8'hF0);
    sx_bad = 0;
    for (int i = 0; i < SYSEX_MAX; i++) begin
      if (i == 500) begin
        for (int k = 0; k < 3; k++) begin
          tick(1, 8'hF8);
          if (parse_error !== 1'b0 || input_en !== 1'b0) sx_bad++;
        end
      end
      tick(1, 8'(i % 128));
      if (parse_error !== 1'b0 || input_en !== 1'b0) sx_bad++;
    end
    chk("sysex_full_payload_clean", 32'(sx_bad), 32'd0);
    tick(1, 8'h55);
    chk("sysex_overflow_perr", 32'(parse_error), 32'd1);
    tick(1, 8'h56);
    chk("sysex_after_abort_stray", 32'(parse_error), 32'd1);

    // Full-length SysEx terminated properly, then a note
    tick(1, 8'hF0);
    sx_bad = 0;
    for (int i = 0; i < SYSEX_MAX; i++) begin
      tick(1, 8'h11);
      if (parse_error !== 1'b0) sx_bad++;
    end
    tick(1, 8'hF7);
    if (parse_error !== 1'b0) sx_bad++;
    chk("sysex_max_terminated", 32'(sx_bad), 32'd0);
    tick(1, 8'h90); tick(1, 8'h24); tick(1, 8'h33);
    check_out("post_sysex_note", 1, 0, 1, 36, 51);

    // Status interrupting SysEx: no error, new message decoded
    tick(1, 8'hF0); tick(1, 8'h01);
    tick(1, 8'h90);
    chk("sysex_interrupt_no_perr", 32'(parse_error), 32'd0);
    tick(1, 8'h3C); tick(1, 8'h64);
    check_out("sysex_interrupt_note", 1, 0, 1, 60, 100);
    tick(0, 8'h00);
    chk("pulse_single_cycle", 32'(input_en), 32'd0);

    // ---------------- randomized stream vs. model ----------------
    do_reset();
    model_reset();
    channel = 4'd0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 2) channel = 4'($urandom);
      r = $urandom_range(0, 99);
      v = 1;
      nib = 4'($urandom);
      if (r < 8) begin
        v = 0; b = 8'($urandom);
      end else if (r < 45) begin
        b = 8'($urandom_range(0, 127));
      end else if (r < 60) begin
        b = {3'b100, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? channel : nib};
      end else if (r < 70) begin
        b = {1'b1, 3'($urandom_range(2, 6)), nib};
      end else if (r < 77) begin
        b = 8'($urandom_range(240, 247));
      end else if (r < 83) begin
        b = 8'($urandom_range(248, 255));
      end else begin
        b = 8'($urandom_range(0, 3));
      end
      ev = 0; perr = 0;
      if (v) model_byte(b, channel, ev, perr);
      tick(v, b);
      check_out($sformatf("rnd%0d_v%0d_b%02h", i, v, b), ev, perr, m_on, m_n, m_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
